drive_ctrl: RTL and testbench

Motor-drive stage directly downstream of the PD math block. On every valid inertial sample it sums the signed P and D terms into a steering correction and ramps the forward speed toward a commanded target. It mixes the two into saturated left/right signed speeds and produces glitch-free 11-bit PWM plus direction for each motor.

---
 rtl/drive_pkg.sv | 39 +++
 rtl/drive_if.sv | 32 +++
 rtl/pwm11.sv | 53 +++++
 rtl/drive_ctrl.sv | 116 +++++++++++
 tb/tb_drive_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/drive_pkg.sv
// drive_pkg: shared types and constants for the drive_ctrl slice.
//   state_t : ramp FSM states
//   dbg_t   : debug view of internal state (FSM state, forward speed, PWM counter)
//   sat12   : saturate a 14-bit signed mix result to 12-bit signed
//   mag11   : PWM magnitude of a 12-bit signed speed (-2048 folds to 2047)
package drive_pkg;

  localparam int PWM_W = 11;
  localparam logic signed [11:0] SPD_MAX = 12'sd2047;
  localparam logic signed [11:0] SPD_MIN = 12'sh800;  // -2048

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2,
    DECEL  = 2'd3
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [10:0]      frwrd_cur;
    logic [PWM_W-1:0] pwm_cnt;
  } dbg_t;

  function automatic logic signed [11:0] sat12(input logic signed [13:0] v);
    if (v > 14'sd2047) return SPD_MAX;
    else if (v < -14'sd2048) return SPD_MIN;
    else return v[11:0];
  endfunction

  function automatic logic [PWM_W-1:0] mag11(input logic signed [11:0] s);
    logic [11:0] neg;
    neg = -s;
    if (s == SPD_MIN) return 11'd2047;
    else if (s[11]) return neg[10:0];
    else return s[10:0];
  endfunction

endpackage

// File: rtl/drive_if.sv
// drive_if: PD-term input bundle and motor-drive output bundle.
//   vld/moving/pterm/dterm/frwrd_tgt : inputs from the PD stage
//   lft_spd/rght_spd/spd_vld         : mixed, saturated signed speeds
//   lft_pwm/rght_pwm/lft_rev/rght_rev: motor drive
// Handshake: vld is a pure qualifier with no backpressure. pterm, dterm,
// moving and frwrd_tgt are sampled on every clock edge where vld=1; each such
// edge is one sample. spd_vld is a one-cycle qualifier for the speed outputs,
// likewise without a ready; the consumer must take it when it appears.
interface drive_if;
  logic               vld;
  logic               moving;
  logic signed [9:0]  pterm;
  logic signed [11:0] dterm;
  logic [10:0]        frwrd_tgt;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               spd_vld;
  logic               lft_pwm;
  logic               rght_pwm;
  logic               lft_rev;
  logic               rght_rev;

  modport master (
    output vld, moving, pterm, dterm, frwrd_tgt,
    input  lft_spd, rght_spd, spd_vld, lft_pwm, rght_pwm, lft_rev, rght_rev
  );

  modport slave (
    input  vld, moving, pterm, dterm, frwrd_tgt,
    output lft_spd, rght_spd, spd_vld, lft_pwm, rght_pwm, lft_rev, rght_rev
  );
endinterface

// File: rtl/pwm11.sv
// pwm11: free-running 11-bit counter shared by two PWM channels.
//   clk, rst_n          : clock, async active-low reset
//   lft_spd, rght_spd   : signed speed requests
//   cnt                 : counter value (debug)
//   lft_pwm, rght_pwm   : registered PWM, high while cnt < duty
//   lft_rev, rght_rev   : direction, sign of the speed
// Duty and direction load only on the 2047->0 wrap so a period is never cut.
module pwm11 import drive_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  output logic [PWM_W-1:0]   cnt,
  output logic               lft_pwm,
  output logic               rght_pwm,
  output logic               lft_rev,
  output logic               rght_rev
);

  logic [PWM_W-1:0] lft_duty, rght_duty;
  logic [PWM_W-1:0] cnt_n, lft_duty_n, rght_duty_n;
  logic             wrap;

  assign wrap        = (cnt == '1);
  assign cnt_n       = cnt + PWM_W'(1);
  assign lft_duty_n  = wrap ? mag11(lft_spd)  : lft_duty;
  assign rght_duty_n = wrap ? mag11(rght_spd) : rght_duty;

  // pwm is registered from next-state values so it equals (cnt < duty)
  // for the counter value present in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lft_duty  <= '0;
      rght_duty <= '0;
      lft_pwm   <= 1'b0;
      rght_pwm  <= 1'b0;
      lft_rev   <= 1'b0;
      rght_rev  <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      lft_duty  <= lft_duty_n;
      rght_duty <= rght_duty_n;
      lft_pwm   <= (cnt_n < lft_duty_n);
      rght_pwm  <= (cnt_n < rght_duty_n);
      if (wrap) begin
        lft_rev  <= lft_spd[11];
        rght_rev <= rght_spd[11];
      end
    end
  end

endmodule

// File: rtl/drive_ctrl.sv
// drive_ctrl: forward-speed ramp FSM, PD correction sum, left/right mixing
// with 12-bit saturation, and PWM generation.
//   RAMP_UP, RAMP_DN : forward-speed step per vld when speeding up / slowing down
//   clk, rst_n       : clock, async active-low reset
//   drv              : drive_if slave (PD inputs, speeds, PWM, direction)
//   dbg              : FSM state, current forward speed, PWM counter
// Pipeline: the vld edge registers pd_sum, frwrd_cur and state; the next edge
// registers the mixed speeds and raises spd_vld for one cycle.
module drive_ctrl import drive_pkg::*; #(
  parameter int RAMP_UP = 8,
  parameter int RAMP_DN = 16
) (
  input  logic clk,
  input  logic rst_n,
  drive_if.slave drv,
  output dbg_t dbg
);

  state_t             state;
  logic [10:0]        cur;
  logic signed [12:0] pd_q;
  logic               vld_q;
  logic signed [11:0] lft_r, rght_r;
  logic               spd_vld_r;
  logic [PWM_W-1:0]   cnt;

  logic [10:0]        eff;
  logic [11:0]        up_sum, dn_dif;
  logic [10:0]        up_val, dn_val, nxt_cur;
  logic signed [12:0] pd_sum;
  logic signed [13:0] cur14, pd14, lft_w, rght_w;

  // Effective ramp target: stopping always ramps toward zero.
  assign eff    = drv.moving ? drv.frwrd_tgt : 11'd0;
  assign up_sum = {1'b0, cur} + 12'(RAMP_UP);
  assign dn_dif = {1'b0, cur} - 12'(RAMP_DN);
  // Steps are taken in 12 bits and clamped at the target, so they never wrap.
  assign up_val = (up_sum > {1'b0, eff}) ? eff : up_sum[10:0];
  assign dn_val = (dn_dif[11] || (dn_dif[10:0] < eff)) ? eff : dn_dif[10:0];
  // A state change and the first step in the new direction share one vld.
  assign nxt_cur = (cur < eff) ? up_val : ((cur > eff) ? dn_val : cur);

  assign pd_sum = {{3{drv.pterm[9]}}, drv.pterm} + {drv.dterm[11], drv.dterm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= '0;
      pd_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= drv.vld;
      if (drv.vld) begin
        pd_q <= pd_sum;
        case (state)
          IDLE: begin
            // Leaving IDLE needs moving=1 and a nonzero target.
            if (eff != 11'd0) begin
              cur   <= nxt_cur;
              state <= (nxt_cur == eff) ? CRUISE : ACCEL;
            end else begin
              cur <= '0;
            end
          end
          default: begin
            cur <= nxt_cur;
            if ((nxt_cur == 11'd0) && !drv.moving) state <= IDLE;
            else if (nxt_cur == eff)               state <= CRUISE;
            else if (nxt_cur < eff)                state <= ACCEL;
            else                                   state <= DECEL;
          end
        endcase
      end
    end
  end

  assign cur14  = {3'b000, cur};
  assign pd14   = {pd_q[12], pd_q};
  assign lft_w  = cur14 + pd14;
  assign rght_w = cur14 - pd14;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_r     <= '0;
      rght_r    <= '0;
      spd_vld_r <= 1'b0;
    end else begin
      spd_vld_r <= vld_q;
      if (vld_q) begin
        lft_r  <= (state == IDLE) ? 12'sd0 : sat12(lft_w);
        rght_r <= (state == IDLE) ? 12'sd0 : sat12(rght_w);
      end
    end
  end

  pwm11 u_pwm (
    .clk      (clk),
    .rst_n    (rst_n),
    .lft_spd  (lft_r),
    .rght_spd (rght_r),
    .cnt      (cnt),
    .lft_pwm  (drv.lft_pwm),
    .rght_pwm (drv.rght_pwm),
    .lft_rev  (drv.lft_rev),
    .rght_rev (drv.rght_rev)
  );

  assign drv.lft_spd  = lft_r;
  assign drv.rght_spd = rght_r;
  assign drv.spd_vld  = spd_vld_r;

  assign dbg.state     = state;
  assign dbg.frwrd_cur = cur;
  assign dbg.pwm_cnt   = cnt;

endmodule

// File: tb/tb_drive_ctrl.sv
// tb_drive_ctrl: self-checking bench for drive_ctrl with a behavioural model.
module tb_drive_ctrl;
  import drive_pkg::*;

  localparam int RAMP_UP = 8;
  localparam int RAMP_DN = 16;

  logic clk;
  logic rst_n;
  dbg_t dbg;
  drive_if drv();

  drive_ctrl #(.RAMP_UP(RAMP_UP), .RAMP_DN(RAMP_DN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .drv   (drv),
    .dbg   (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];

  // ---------------- reference model ----------------
  state_t m_state = IDLE;
  int     m_cur   = 0;
  int     m_lft   = 0;
  int     m_rght  = 0;

  function automatic int clamp12(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic model_step(input bit mv, input int tgt, input int pd);
    int eff;
    eff = mv ? tgt : 0;
    if (!(m_state == IDLE && eff == 0)) begin
      if (m_cur < eff)      m_cur = (m_cur + RAMP_UP > eff) ? eff : m_cur + RAMP_UP;
      else if (m_cur > eff) m_cur = (m_cur - RAMP_DN < eff) ? eff : m_cur - RAMP_DN;
      if (m_cur == 0 && !mv)  m_state = IDLE;
      else if (m_cur == eff)  m_state = CRUISE;
      else if (m_cur < eff)   m_state = ACCEL;
      else                    m_state = DECEL;
    end
    m_lft  = (m_state == IDLE) ? 0 : clamp12(m_cur + pd);
    m_rght = (m_state == IDLE) ? 0 : clamp12(m_cur - pd);
  endtask

  // ---------------- drivers ----------------
  logic signed [11:0] obs_lft, obs_rght;
  logic               obs_vld;
  state_t             obs_state;
  int                 obs_cur;

  // One vld sample; observes outputs in the cycle after the vld edge.
  task automatic send(input bit mv, input int tgt, input int p, input int d);
    @(negedge clk);
    drv.moving    = mv;
    drv.frwrd_tgt = 11'(tgt);
    drv.pterm     = 10'(p);
    drv.dterm     = 12'(d);
    drv.vld       = 1'b1;
    @(posedge clk); #1;
    drv.vld = 1'b0;
    model_step(mv, tgt, p + d);
    @(posedge clk); #1;
    obs_lft   = drv.lft_spd;
    obs_rght  = drv.rght_spd;
    obs_vld   = drv.spd_vld;
    obs_state = dbg.state;
    obs_cur   = int'(dbg.frwrd_cur);
  endtask

  // Waits for the next counter wrap, then counts high cycles over one period.
  task automatic measure_pwm(output int lh, output int rh);
    int guard;
    guard = 0;
    lh = 0;
    rh = 0;
    while (dbg.pwm_cnt !== 11'h7FF && guard < 2100) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++;
    if (guard >= 2100) begin
      n_fail++;
      $display("FAIL pwm_wrap_wait: waited %0d cycles, required wrap within 2100", guard);
    end
    for (int i = 0; i < 2048; i++) begin
      @(posedge clk); #1;
      lh += int'(drv.lft_pwm);
      rh += int'(drv.rght_pwm);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #25;
    n_checks++;
    if ({drv.lft_spd, drv.rght_spd, drv.spd_vld, drv.lft_pwm, drv.rght_pwm,
         drv.lft_rev, drv.rght_rev} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got lft=%0d rght=%0d vld=%b pwm=%b%b rev=%b%b, required all 0",
               drv.lft_spd, drv.rght_spd, drv.spd_vld, drv.lft_pwm, drv.rght_pwm,
               drv.lft_rev, drv.rght_rev);
    end
    n_checks++;
    if (dbg !== '0) begin
      n_fail++;
      $display("FAIL reset_dbg: got state=%0d cur=%0d cnt=%0d, required all 0",
               dbg.state, dbg.frwrd_cur, dbg.pwm_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      send(1'b0, int'($urandom_range(0, 2047)), 100 + i, -300);
      n_checks++;
      if (obs_state !== IDLE || obs_lft !== 12'sd0 || obs_rght !== 12'sd0) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: got state=%s lft=%0d rght=%0d, required IDLE 0 0",
                 i, obs_state.name(), obs_lft, obs_rght);
      end
      n_checks++;
      if (obs_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_spd_vld[%0d]: got %b required 1", i, obs_vld);
      end
      @(posedge clk); #1;
      n_checks++;
      if (drv.spd_vld !== 1'b0 || drv.lft_pwm !== 1'b0 || drv.rght_pwm !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet[%0d]: got spd_vld=%b pwm=%b%b, required 0 00",
                 i, drv.spd_vld, drv.lft_pwm, drv.rght_pwm);
      end
    end
  endtask

  task automatic test_accel();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 40, 0, 0);
      n_checks++;
      if (obs_cur != 8 * (i + 1) || obs_lft !== 12'(8 * (i + 1)) || obs_rght !== obs_lft) begin
        n_fail++;
        $display("FAIL accel_step[%0d]: got cur=%0d lft=%0d rght=%0d, required %0d each",
                 i, obs_cur, obs_lft, obs_rght, 8 * (i + 1));
      end
      n_checks++;
      if (obs_state !== ((i == 4) ? CRUISE : ACCEL)) begin
        n_fail++;
        $display("FAIL accel_state[%0d]: got %s required %s", i, obs_state.name(),
                 (i == 4) ? "CRUISE" : "ACCEL");
      end
    end
  endtask

  task automatic test_back_to_back();
    int p, d;
    logic [23:0] got, want;
    p = 0;
    d = 0;
    exp_q.delete();
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i < 6) begin
        p = int'($urandom_range(0, 1023)) - 512;
        d = int'($urandom_range(0, 4095)) - 2048;
        drv.vld       = 1'b1;
        drv.moving    = 1'b1;
        drv.frwrd_tgt = 11'd40;
        drv.pterm     = 10'(p);
        drv.dterm     = 12'(d);
      end else begin
        drv.vld = 1'b0;
      end
      @(posedge clk); #1;
      if (i > 0) begin
        want = exp_q.pop_front();
        got  = {drv.lft_spd, drv.rght_spd};
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL b2b_speed[%0d]: got lft=%0d rght=%0d, required lft=%0d rght=%0d",
                   i - 1, $signed(got[23:12]), $signed(got[11:0]),
                   $signed(want[23:12]), $signed(want[11:0]));
        end
        n_checks++;
        if (drv.spd_vld !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_spd_vld[%0d]: got %b required 1", i - 1, drv.spd_vld);
        end
      end
      if (i < 6) begin
        model_step(1'b1, 40, p + d);
        exp_q.push_back({12'(m_lft), 12'(m_rght)});
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (drv.spd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_spd_vld_end: got %b required 0", drv.spd_vld);
    end
  endtask

  task automatic test_mix();
    int lh, rh;
    for (int i = 0; i < 200 && m_cur != 1000; i++) send(1'b1, 1000, 0, 0);
    send(1'b1, 1000, 200, -50);
    n_checks++;
    if (obs_state !== CRUISE || obs_cur != 1000 || obs_lft !== 12'sd1150 || obs_rght !== 12'sd850) begin
      n_fail++;
      $display("FAIL mix_1000: got state=%s cur=%0d lft=%0d rght=%0d, required CRUISE 1000 1150 850",
               obs_state.name(), obs_cur, obs_lft, obs_rght);
    end
    measure_pwm(lh, rh);
    n_checks++;
    if (lh != 1150 || rh != 850 || drv.lft_rev !== 1'b0 || drv.rght_rev !== 1'b0) begin
      n_fail++;
      $display("FAIL mix_pwm: got duty %0d/%0d rev %b%b, required 1150/850 rev 00",
               lh, rh, drv.lft_rev, drv.rght_rev);
    end
  endtask

  task automatic test_saturation();
    int lh, rh;
    for (int i = 0; i < 200 && m_cur != 2000; i++) send(1'b1, 2000, 0, 0);
    send(1'b1, 2000, 511, 2047);
    n_checks++;
    if (obs_cur != 2000 || obs_lft !== 12'sd2047 || obs_rght !== -12'sd558) begin
      n_fail++;
      $display("FAIL sat_speed: got cur=%0d lft=%0d rght=%0d, required 2000 2047 -558",
               obs_cur, obs_lft, obs_rght);
    end
    // The new negative speed must not reach rev before the next wrap.
    n_checks++;
    if (drv.rght_rev !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_rev_early: got rght_rev=%b required 0 until wrap", drv.rght_rev);
    end
    measure_pwm(lh, rh);
    n_checks++;
    if (lh != 2047 || rh != 558 || drv.lft_rev !== 1'b0 || drv.rght_rev !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pwm: got duty %0d/%0d rev %b%b, required 2047/558 rev 01",
               lh, rh, drv.lft_rev, drv.rght_rev);
    end
  endtask

  task automatic test_decel();
    int exp_cur[3];
    int exp_l[3];
    int exp_r[3];
    state_t exp_s[3];
    exp_cur = '{24, 8, 0};
    exp_l   = '{124, 108, 0};
    exp_r   = '{-76, -92, 0};
    exp_s   = '{DECEL, DECEL, IDLE};
    for (int i = 0; i < 200 && m_cur != 40; i++) send(1'b1, 40, 0, 0);
    n_checks++;
    if (obs_state !== CRUISE || obs_cur != 40) begin
      n_fail++;
      $display("FAIL decel_start: got state=%s cur=%0d, required CRUISE 40", obs_state.name(), obs_cur);
    end
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 40, 100, 0);
      n_checks++;
      if (obs_state !== exp_s[i] || obs_cur != exp_cur[i] ||
          obs_lft !== 12'(exp_l[i]) || obs_rght !== 12'(exp_r[i])) begin
        n_fail++;
        $display("FAIL decel_step[%0d]: got state=%s cur=%0d lft=%0d rght=%0d, required %s %0d %0d %0d",
                 i, obs_state.name(), obs_cur, obs_lft, obs_rght, exp_s[i].name(),
                 exp_cur[i], exp_l[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_random();
    bit mv;
    int tgt, p, d, sel;
    tgt = 0;
    for (int i = 0; i < 150; i++) begin
      if (i % 8 == 0) begin
        sel = int'($urandom_range(0, 2));
        tgt = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(0, 64)) : int'($urandom_range(0, 2047));
      end
      mv = ($urandom_range(0, 3) != 0);
      p  = int'($urandom_range(0, 1023)) - 512;
      d  = int'($urandom_range(0, 4095)) - 2048;
      send(mv, tgt, p, d);
      n_checks++;
      if (obs_state !== m_state || obs_cur != m_cur) begin
        n_fail++;
        $display("FAIL rand_ramp[%0d]: got state=%s cur=%0d, required %s %0d",
                 i, obs_state.name(), obs_cur, m_state.name(), m_cur);
      end
      n_checks++;
      if (obs_lft !== 12'(m_lft) || obs_rght !== 12'(m_rght) || obs_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_speed[%0d]: got lft=%0d rght=%0d vld=%b, required %0d %0d 1",
                 i, obs_lft, obs_rght, obs_vld, m_lft, m_rght);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 200 && m_state != IDLE; i++) send(1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) send(1'b1, 500, 0, 0);
    n_checks++;
    if (obs_state !== ACCEL || obs_cur != 24 || obs_lft !== 12'sd24) begin
      n_fail++;
      $display("FAIL rstmid_pre: got state=%s cur=%0d lft=%0d, required ACCEL 24 24",
               obs_state.name(), obs_cur, obs_lft);
    end
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({drv.lft_spd, drv.rght_spd, drv.spd_vld, drv.lft_pwm, drv.rght_pwm,
         drv.lft_rev, drv.rght_rev} !== '0 || dbg !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got lft=%0d rght=%0d vld=%b pwm=%b%b rev=%b%b state=%0d cur=%0d, required all 0",
               drv.lft_spd, drv.rght_spd, drv.spd_vld, drv.lft_pwm, drv.rght_pwm,
               drv.lft_rev, drv.rght_rev, dbg.state, dbg.frwrd_cur);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    m_state = IDLE;
    m_cur   = 0;
    send(1'b0, 0, 50, 50);
    n_checks++;
    if (obs_state !== IDLE || obs_cur != 0 || obs_lft !== 12'sd0 || obs_rght !== 12'sd0) begin
      n_fail++;
      $display("FAIL rstmid_after: got state=%s cur=%0d lft=%0d rght=%0d, required IDLE 0 0 0",
               obs_state.name(), obs_cur, obs_lft, obs_rght);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n         = 1'b0;
    drv.vld       = 1'b0;
    drv.moving    = 1'b0;
    drv.pterm     = '0;
    drv.dterm     = '0;
    drv.frwrd_tgt = '0;
    test_reset();
    test_idle();
    test_accel();
    test_back_to_back();
    test_mix();
    test_saturation();
    test_decel();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
